// File: rtl/dma_req_arbiter_pkg.sv
// rtl/dma_req_arbiter_pkg.sv - shared types, constants and helpers for the DMA request arbiter
package dma_req_arbiter_pkg;

  localparam int BEAT_W = 9;   // outstanding response count, up to 256
  localparam int PTR_W  = 3;   // requester index, up to 8 requesters
  localparam int CNT_W  = 16;  // per-requester grant counter

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    state_e             state;
    logic [PTR_W-1:0]   rr_ptr;    // last granted requester; also the current grant
    logic [BEAT_W-1:0]  resp_cnt;  // responses still owed to the granted requester
  } regs_t;

  // rr_ptr is overridden to nreq-1 by the instantiating module
  localparam regs_t REGS_RST = '{state: ST_IDLE, rr_ptr: '0, resp_cnt: '0};

  // Number of read response beats for a burst; a length field of 0 means 1024 bytes
  function automatic logic [BEAT_W-1:0] read_beats(input logic [9:0] bytes, input logic is64);
    logic [10:0] len;
    len = (bytes == 10'd0) ? 11'd1024 : {1'b0, bytes};
    return is64 ? {1'b0, len[10:3]} : len[10:2];
  endfunction

endpackage

// File: rtl/dma_rr_picker.sv
// rtl/dma_rr_picker.sv - combinational round-robin pick starting after the last grant
module dma_rr_picker
  import dma_req_arbiter_pkg::*;
#(
  parameter int nreq = 4
) (
  input  logic [nreq-1:0]  i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  // Scan from farthest to nearest so the nearest valid index after i_ptr wins
  always_comb begin
    o_any = 1'b0;
    o_idx = i_ptr;
    for (int k = nreq; k >= 1; k--) begin
      if (i_valid[(int'(i_ptr) + k) % nreq]) begin
        o_any = 1'b1;
        o_idx = PTR_W'((int'(i_ptr) + k) % nreq);
      end
    end
  end

endmodule

// File: rtl/dma_req_arbiter.sv
// rtl/dma_req_arbiter.sv - round-robin DMA request arbiter; grant counters under DMA_REQ_ARBITER_STATS_EN
module dma_req_arbiter
  import dma_req_arbiter_pkg::*;
#(
  parameter int nreq  = 4,
  parameter int abits = 48
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [nreq-1:0]       i_req_valid,
  output logic [nreq-1:0]       o_req_ready,
  input  logic [nreq-1:0]       i_req_64,
  input  logic [nreq-1:0]       i_req_write,
  input  logic [nreq-1:0]       i_req_last,
  input  logic [nreq*10-1:0]    i_req_bytes,
  input  logic [nreq*abits-1:0] i_req_addr,
  input  logic [nreq*8-1:0]     i_req_strob,
  input  logic [nreq*64-1:0]    i_req_data,
  output logic [nreq-1:0]       o_resp_valid,
  input  logic [nreq-1:0]       i_resp_ready,
  output logic [63:0]           o_resp_data,
  output logic                  o_resp_fault,
  output logic                  o_dma_req_valid,
  output logic                  o_dma_req_64,
  output logic                  o_dma_req_write,
  output logic [9:0]            o_dma_req_bytes,
  output logic [abits-1:0]      o_dma_req_addr,
  output logic [7:0]            o_dma_req_strob,
  output logic [63:0]           o_dma_req_data,
  output logic                  o_dma_req_last,
  input  logic                  i_dma_req_ready,
  input  logic                  i_dma_resp_valid,
  input  logic [63:0]           i_dma_resp_data,
  input  logic                  i_dma_resp_fault,
  output logic                  o_dma_resp_ready,
  output logic [nreq*16-1:0]    o_grant_cnt
);

  regs_t            r_q;
  regs_t            w_d;
  logic [PTR_W-1:0] w_g;
  logic [PTR_W-1:0] w_pick;
  logic             w_any;
  logic             w_beat_acc;
  logic             w_resp_hs;
  logic             w_done;
  logic [nreq-1:0]  w_req_ready;
  logic [nreq-1:0]  w_resp_valid;
  logic             w_dma_req_valid;
  logic             w_dma_resp_ready;

  assign w_g        = r_q.rr_ptr;
  assign w_beat_acc = (r_q.state == ST_FWD) && i_req_valid[w_g] && i_dma_req_ready;
  assign w_resp_hs  = (r_q.state == ST_RESP) && i_dma_resp_valid && i_resp_ready[w_g];
  assign w_done     = w_resp_hs && (r_q.resp_cnt == BEAT_W'(1));

  dma_rr_picker #(.nreq(nreq)) u_picker (
    .i_valid (i_req_valid),
    .i_ptr   (r_q.rr_ptr),
    .o_idx   (w_pick),
    .o_any   (w_any)
  );

  // State register; reset parks the pointer on the last requester so index 0 wins first
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_q        <= REGS_RST;
      r_q.rr_ptr <= PTR_W'(nreq - 1);
    end else begin
      r_q <= w_d;
    end
  end

  // Next state and per-requester handshake steering
  always_comb begin
    w_d              = r_q;
    w_req_ready      = '0;
    w_resp_valid     = '0;
    w_dma_req_valid  = 1'b0;
    w_dma_resp_ready = 1'b1;
    case (r_q.state)
      ST_IDLE: begin
        if (w_any) begin
          w_d.state  = ST_FWD;
          w_d.rr_ptr = w_pick;
        end
      end
      ST_FWD: begin
        w_dma_req_valid  = i_req_valid[w_g];
        w_req_ready[w_g] = i_dma_req_ready;
        if (w_beat_acc) begin
          // resp_cnt is zero only before the first beat of a burst
          if (r_q.resp_cnt == '0) begin
            w_d.resp_cnt = i_req_write[w_g] ? BEAT_W'(1)
                         : read_beats(i_req_bytes[w_g*10 +: 10], i_req_64[w_g]);
          end
          if (i_req_last[w_g]) begin
            w_d.state = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        w_resp_valid[w_g] = i_dma_resp_valid;
        w_dma_resp_ready  = i_resp_ready[w_g];
        if (w_resp_hs) begin
          w_d.resp_cnt = r_q.resp_cnt - BEAT_W'(1);
        end
        if (w_done) begin
          w_d.state = ST_IDLE;
        end
      end
      default: begin
        w_d.state = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are forced quiet while reset is held
  assign o_req_ready      = i_nrst ? w_req_ready : '0;
  assign o_resp_valid     = i_nrst ? w_resp_valid : '0;
  assign o_dma_req_valid  = i_nrst && w_dma_req_valid;
  assign o_dma_resp_ready = !i_nrst || w_dma_resp_ready;

  assign o_dma_req_64    = i_req_64[w_g];
  assign o_dma_req_write = i_req_write[w_g];
  assign o_dma_req_last  = i_req_last[w_g];
  assign o_dma_req_bytes = i_req_bytes[w_g*10 +: 10];
  assign o_dma_req_addr  = i_req_addr[w_g*abits +: abits];
  assign o_dma_req_strob = i_req_strob[w_g*8 +: 8];
  assign o_dma_req_data  = i_req_data[w_g*64 +: 64];
  assign o_resp_data     = i_dma_resp_data;
  assign o_resp_fault    = i_dma_resp_fault;

`ifdef DMA_REQ_ARBITER_STATS_EN
  logic [CNT_W-1:0] r_grant_cnt [nreq];

  // Count completed transactions per requester, wrapping naturally
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      for (int k = 0; k < nreq; k++) begin
        r_grant_cnt[k] <= '0;
      end
    end else if (w_done) begin
      r_grant_cnt[w_g] <= r_grant_cnt[w_g] + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < nreq; k++) begin : g_cnt_out
    assign o_grant_cnt[k*16 +: 16] = r_grant_cnt[k];
  end
`else
  assign o_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_dma_req_arbiter.sv
// tb/tb_dma_req_arbiter.sv - self-checking bench for dma_req_arbiter
module tb_dma_req_arbiter;

  localparam int NREQ  = 4;
  localparam int ABITS = 48;

  logic                  i_clk;
  logic                  i_nrst;
  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ-1:0]       o_req_ready;
  logic [NREQ-1:0]       i_req_64;
  logic [NREQ-1:0]       i_req_write;
  logic [NREQ-1:0]       i_req_last;
  logic [NREQ*10-1:0]    i_req_bytes;
  logic [NREQ*ABITS-1:0] i_req_addr;
  logic [NREQ*8-1:0]     i_req_strob;
  logic [NREQ*64-1:0]    i_req_data;
  logic [NREQ-1:0]       o_resp_valid;
  logic [NREQ-1:0]       i_resp_ready;
  logic [63:0]           o_resp_data;
  logic                  o_resp_fault;
  logic                  o_dma_req_valid;
  logic                  o_dma_req_64;
  logic                  o_dma_req_write;
  logic [9:0]            o_dma_req_bytes;
  logic [ABITS-1:0]      o_dma_req_addr;
  logic [7:0]            o_dma_req_strob;
  logic [63:0]           o_dma_req_data;
  logic                  o_dma_req_last;
  logic                  i_dma_req_ready;
  logic                  i_dma_resp_valid;
  logic [63:0]           i_dma_resp_data;
  logic                  i_dma_resp_fault;
  logic                  o_dma_resp_ready;
  logic [NREQ*16-1:0]    o_grant_cnt;

  int checks = 0;
  int errors = 0;
  int exp_rr;
  int exp_gcnt [NREQ];

  dma_req_arbiter #(.nreq(NREQ), .abits(ABITS)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_64(i_req_64), .i_req_write(i_req_write), .i_req_last(i_req_last),
    .i_req_bytes(i_req_bytes), .i_req_addr(i_req_addr),
    .i_req_strob(i_req_strob), .i_req_data(i_req_data),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_data(o_resp_data), .o_resp_fault(o_resp_fault),
    .o_dma_req_valid(o_dma_req_valid), .o_dma_req_64(o_dma_req_64),
    .o_dma_req_write(o_dma_req_write), .o_dma_req_bytes(o_dma_req_bytes),
    .o_dma_req_addr(o_dma_req_addr), .o_dma_req_strob(o_dma_req_strob),
    .o_dma_req_data(o_dma_req_data), .o_dma_req_last(o_dma_req_last),
    .i_dma_req_ready(i_dma_req_ready),
    .i_dma_resp_valid(i_dma_resp_valid), .i_dma_resp_data(i_dma_resp_data),
    .i_dma_resp_fault(i_dma_resp_fault), .o_dma_resp_ready(o_dma_resp_ready),
    .o_grant_cnt(o_grant_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Round robin: first valid requester strictly after the last grant, wrapping
  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [63:0] exp_gvec();
    logic [63:0] v;
    v = '0;
`ifdef DMA_REQ_ARBITER_STATS_EN
    for (int k = 0; k < NREQ; k++) v[k*16 +: 16] = 16'(exp_gcnt[k]);
`endif
    return v;
  endfunction

  function automatic int resp_count(input bit wr, input bit b64, input logic [9:0] bytes);
    int len;
    if (wr) return 1;
    len = (bytes == 10'd0) ? 1024 : int'(bytes);
    return b64 ? len / 8 : len / 4;
  endfunction

  task automatic model_reset();
    exp_rr = NREQ - 1;
    for (int k = 0; k < NREQ; k++) exp_gcnt[k] = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_ready"}, 64'(o_req_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(o_resp_valid), 64'd0);
    chk({tag, "_dma_valid"}, 64'(o_dma_req_valid), 64'd0);
    chk({tag, "_dma_resp_ready"}, 64'(o_dma_resp_ready), 64'd1);
  endtask

  // From IDLE present valid vector v; the model's choice must be granted one cycle later
  task automatic grant(input logic [NREQ-1:0] v, output int g);
    logic [NREQ-1:0] e;
    g = pick(v, exp_rr);
    i_req_valid = v;
    i_dma_req_ready = 1'b1;
    i_dma_resp_valid = 1'b0;
    #1;
    chk("idle_req_ready", 64'(o_req_ready), 64'd0);
    chk("idle_dma_valid", 64'(o_dma_req_valid), 64'd0);
    cyc();
    e = '0;
    e[g] = 1'b1;
    chk("grant", 64'(o_req_ready), 64'(e));
    exp_rr = g;
  endtask

  // Drive a full transaction for granted requester g and take all owed responses
  task automatic run_txn(input int g, input bit wr, input bit b64, input logic [9:0] bytes,
                         input int wbeats, input int stall_at);
    int nb, n, k, st, guard;
    logic [NREQ-1:0] e;
    logic [63:0] tmp, d;
    logic [47:0] a;
    logic [7:0] s;
    n = resp_count(wr, b64, bytes);
    nb = wr ? wbeats : 1;
    tmp = rnd64();
    a = tmp[47:0];
    i_req_64[g] = b64;
    i_req_write[g] = wr;
    i_req_bytes[g*10 +: 10] = bytes;
    i_req_addr[g*ABITS +: ABITS] = a;
    k = 0;
    while (k < nb) begin
      d = rnd64();
      tmp = rnd64();
      s = tmp[7:0];
      i_req_data[g*64 +: 64] = d;
      i_req_strob[g*8 +: 8] = s;
      i_req_last[g] = (k == nb - 1);
      i_req_valid[g] = 1'b1;
      i_dma_req_ready = ($urandom_range(0, 3) != 0);
      i_dma_resp_valid = $urandom_range(0, 1) == 1;
      i_resp_ready = 4'($urandom);
      #1;
      e = '0;
      e[g] = i_dma_req_ready;
      chk("fwd_req_ready", 64'(o_req_ready), 64'(e));
      chk("fwd_dma_valid", 64'(o_dma_req_valid), 64'd1);
      chk("fwd_dma_addr", 64'(o_dma_req_addr), 64'(a));
      chk("fwd_dma_data", o_dma_req_data, d);
      chk("fwd_dma_ctrl",
          64'({o_dma_req_64, o_dma_req_write, o_dma_req_bytes, o_dma_req_last, o_dma_req_strob}),
          64'({b64, wr, bytes, (k == nb - 1), s}));
      chk("fwd_resp_dropped", 64'(o_resp_valid), 64'd0);
      chk("fwd_dma_resp_ready", 64'(o_dma_resp_ready), 64'd1);
      if (i_dma_req_ready) k++;
      cyc();
    end
    i_req_valid[g] = 1'b0;
    i_dma_req_ready = 1'b0;
    k = 0;
    st = 0;
    guard = 0;
    while (k < n && guard < 5000) begin
      i_dma_resp_valid = ($urandom_range(0, 4) != 0);
      i_dma_resp_data = rnd64();
      i_dma_resp_fault = $urandom_range(0, 7) == 0;
      i_resp_ready = 4'($urandom);
      i_resp_ready[g] = ($urandom_range(0, 3) != 0);
      if (k == stall_at && st < 5) begin
        i_dma_resp_valid = 1'b1;
        i_resp_ready[g] = 1'b0;
        st++;
      end
      #1;
      e = '0;
      e[g] = i_dma_resp_valid;
      chk("resp_valid", 64'(o_resp_valid), 64'(e));
      chk("resp_dma_ready", 64'(o_dma_resp_ready), 64'(i_resp_ready[g]));
      chk("resp_dma_valid", 64'(o_dma_req_valid), 64'd0);
      if (i_dma_resp_valid) begin
        chk("resp_data", o_resp_data, i_dma_resp_data);
        chk("resp_fault", 64'(o_resp_fault), 64'(i_dma_resp_fault));
      end
      if (i_dma_resp_valid && i_resp_ready[g]) k++;
      guard++;
      cyc();
    end
    // Back in IDLE: a stray DMA response must be swallowed
    i_dma_resp_valid = 1'b1;
    i_resp_ready = '1;
    #1;
    chk("idle_drop_valid", 64'(o_resp_valid), 64'd0);
    chk("idle_drop_ready", 64'(o_dma_resp_ready), 64'd1);
    exp_gcnt[g] = (exp_gcnt[g] + 1) & 16'hFFFF;
    chk("grant_cnt", o_grant_cnt, exp_gvec());
    i_dma_resp_valid = 1'b0;
    i_resp_ready = '0;
  endtask

  initial begin
    int g;
    logic [NREQ-1:0] v;
    bit wr, b64;
    logic [9:0] bytes;
    i_nrst = 1'b0;
    i_req_valid = '0; i_req_64 = '0; i_req_write = '0; i_req_last = '0;
    i_req_bytes = '0; i_req_addr = '0; i_req_strob = '0; i_req_data = '0;
    i_resp_ready = '0; i_dma_req_ready = 1'b0; i_dma_resp_valid = 1'b0;
    i_dma_resp_data = '0; i_dma_resp_fault = 1'b0;

    // Reset with every input trying to provoke activity
    cyc();
    i_req_valid = '1; i_dma_req_ready = 1'b1; i_dma_resp_valid = 1'b1; i_resp_ready = '1;
    cyc();
    #1;
    chk_quiet("rst");
    i_nrst = 1'b1;
    i_req_valid = '0;
    i_dma_resp_valid = 1'b0;
    model_reset();
    #1;
    chk_quiet("post_rst");
    chk("post_rst_gcnt", o_grant_cnt, 64'd0);

    // Requesters 0 and 2 contend right after reset
    grant(4'b0101, g);
    run_txn(g, 1'b0, 1'b1, 10'd16, 1, -1);
    grant(4'b0100, g);
    run_txn(g, 1'b0, 1'b0, 10'd8, 1, -1);
    chk("gcnt_two", o_grant_cnt, exp_gvec());

    // Requester 3 writes 4 beats while requester 0 waits
    grant(4'b1001, g);
    run_txn(g, 1'b1, 1'b1, 10'd32, 4, -1);
    grant(4'b0001, g);
    run_txn(g, 1'b0, 1'b0, 10'd12, 1, -1);

    // Requester 1 reads 64 bytes as 64-bit beats
    grant(4'b0010, g);
    run_txn(g, 1'b0, 1'b1, 10'd64, 1, -1);

    // Requester 1 asks again straight after completing; 3 goes first
    grant(4'b1010, g);
    run_txn(g, 1'b1, 1'b0, 10'd4, 2, -1);
    grant(4'b0010, g);
    run_txn(g, 1'b0, 1'b1, 10'd24, 1, -1);

    // 1024-byte 32-bit read with a 5-cycle consumer stall
    grant(4'b0100, g);
    run_txn(g, 1'b0, 1'b0, 10'd0, 1, 100);

    // Reset mid-burst with 3 write beats outstanding
    grant(4'b0010, g);
    i_req_write[g] = 1'b1;
    i_req_last[g] = 1'b0;
    i_dma_req_ready = 1'b1;
    cyc();
    i_nrst = 1'b0;
    #1;
    chk_quiet("rst_mid");
    cyc();
    i_nrst = 1'b1;
    model_reset();
    #1;
    chk_quiet("rst_mid_after");
    chk("rst_mid_gcnt", o_grant_cnt, 64'd0);
    grant(4'b1010, g);
    run_txn(g, 1'b1, 1'b1, 10'd40, 3, -1);

    // Randomized traffic
    for (int t = 0; t < 24; t++) begin
      v = 4'($urandom_range(1, 15));
      grant(v, g);
      wr = $urandom_range(0, 1) == 1;
      b64 = $urandom_range(0, 1) == 1;
      if (wr) bytes = 10'($urandom);
      else if (b64) bytes = 10'($urandom_range(1, 8) * 8);
      else bytes = 10'($urandom_range(1, 16) * 4);
      run_txn(g, wr, b64, bytes, $urandom_range(1, 4), $urandom_range(0, 1) == 1 ? 0 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_req_arbiter.md
DMA_REQ_ARBITER -- requirements
Module: dma_req_arbiter

Interface
REQ-001 Parameter: nreq, 4, number of requesters (2..8).
REQ-002 Parameter: abits, 48, request address width.
REQ-003 i_clk  in  1  clock; all logic on rising edge.
REQ-004 i_nrst  in  1  reset, synchronous, active-low.
REQ-005 i_req_valid / o_req_ready  in / out  nreq  per-requester request handshake.
REQ-006 i_req_64, i_req_write, i_req_last  in  nreq each  per-requester size flag, direction and last-beat flag.
REQ-007 i_req_bytes  in  nreq x 10  burst length in bytes; 0 means 1024.
REQ-008 i_req_addr  in  nreq x abits  address.
REQ-009 i_req_strob / i_req_data  in  nreq x 8 / nreq x 64  write strobe and data.
REQ-010 o_resp_valid / i_resp_ready  out / in  nreq  per-requester response handshake.
REQ-011 o_resp_data / o_resp_fault  out  64 / 1  response payload shared by all requesters, qualified by o_resp_valid.
REQ-012 o_dma_req_* (valid, 64, write, bytes, addr, strob, data, last) / i_dma_req_ready  out / in  DMA-side request port.
REQ-013 i_dma_resp_valid, i_dma_resp_data, i_dma_resp_fault / o_dma_resp_ready  in / out  DMA-side response port.
REQ-014 o_grant_cnt  out  nreq x 16  per-requester count of granted transactions.

Function
REQ-015 States: IDLE, FWD (forward request beats), RESP (await responses).
REQ-016 IDLE: if any i_req_valid is set, the next cycle SHALL grant the first valid requester searching from rr_ptr+1 mod nreq upward, set rr_ptr to that index, and enter FWD; arbitration latency is 1 cycle.
REQ-017 FWD: o_dma_req_* mirror the granted requester combinationally; o_req_ready[g] = i_dma_req_ready; all other o_req_ready bits are 0.
REQ-018 On the first accepted beat, resp_cnt is loaded: a read loads beats = bytes/8 (64-bit) or bytes/4 (32-bit), with bytes=0 meaning 1024 (max 256, 9 bits); a write loads 1.
REQ-019 An accepted beat with last=1 moves FWD to RESP; the grant holds across all write beats and never switches mid-burst.
REQ-020 RESP: o_resp_valid[g] = i_dma_resp_valid, o_dma_resp_ready = i_resp_ready[g], and data and fault pass through; each completed handshake decrements resp_cnt.
REQ-021 When resp_cnt transitions 1 to 0, the next state is IDLE, and o_grant_cnt[g] SHALL increment, wrapping at 0xFFFF.
REQ-022 A requester re-asserting valid in the same cycle its transaction completes is arbitrated in IDLE after all others, per rr_ptr.
REQ-023 In IDLE and FWD, o_dma_resp_ready = 1 and any DMA response is discarded, never routed.
REQ-024 A fault response does not abort; the counting rules above still apply.

Reset
REQ-025 Low i_nrst at a clock edge SHALL force IDLE, rr_ptr = nreq-1, resp_cnt = 0 and o_grant_cnt = 0, even mid-burst.
REQ-026 Values during and after reset: o_req_ready = 0, o_resp_valid = 0, o_dma_req_valid = 0, o_dma_resp_ready = 1.

Configuration
REQ-027 Macro DMA_REQ_ARBITER_STATS_EN: when defined, o_grant_cnt counters are implemented; when undefined, o_grant_cnt is tied to 0 and no counter flops exist.

Structure
REQ-028 Package dma_req_arbiter_pkg holds the state enum, the register struct, its reset constant and the 9-bit beat-count width constant.
REQ-029 Sub-module dma_rr_picker is combinational: inputs are the valid vector and rr_ptr; outputs are the grant index and an any-valid flag.

Verification
REQ-030 Reset low mid-FWD with 3 beats outstanding: next cycle is IDLE, all o_req_ready = 0, o_dma_req_valid = 0.
REQ-031 Requesters 0 and 2 both valid after reset: 0 is granted first, then 2; o_grant_cnt = {0,1,0,1}.
REQ-032 Req1 reads 64 bytes, 64-bit (8 beats): 8 responses route only to requester 1; the 9th response in IDLE is dropped.
REQ-033 Req3 writes 4 beats while req0 is valid throughout: req0 is not granted until req3's single write response completes.
REQ-034 Read with bytes=0, 32-bit: 256 responses are expected; state is still RESP after 255 and IDLE after the 256th.
REQ-035 i_resp_ready held low for 5 cycles in RESP: o_dma_resp_ready = 0 and resp_cnt is unchanged until ready rises.
